instruction_loader: RTL and testbench

- Write-side companion to the instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues one word write per word into instruction memory at word addresses starting at 0.
- Holds the core in stall (`cpu_stall`) from the `start` pulse until all requested words are written.
- Sits between the host/boot byte source and the instruction memory write port.

---
 rtl/instruction_loader_if.sv | 44 ++++
 rtl/instruction_loader.sv | 202 ++++++++++++++++++++
 tb/tb_instruction_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_loader_if                                                |
// | Boot byte stream, load control and imem write-port bundle.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface instruction_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [ADDR_WIDTH:0]   load_len;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  busy;
  logic                  done;
  logic                  cpu_stall;
`ifdef LOADER_CHECKSUM_EN
  logic                  error;

  modport master (
    output start, load_len, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_stall, error
  );
  modport slave (
    input  start, load_len, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_stall, error
  );
`else
  modport master (
    output start, load_len, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_stall
  );
  modport slave (
    input  start, load_len, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_stall
  );
`endif
endinterface
`default_nettype wire

// File: rtl/instruction_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_loader                                                   |
// | Assembles LE 32-bit words from a byte stream and writes them to imem |
// | from word 0, stalling the core meanwhile. LOADER_CHECKSUM_EN adds a  |
// | trailing checksum word and the error flag.                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instruction_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  wire logic         clk,
  input  wire logic         rst,
  instruction_loader_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] c_DEPTH_LEN = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_ONE       = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_CHK   = 3'd4
  } state_t;

  state_t                r_state,      w_state_nxt;
  logic [ADDR_WIDTH:0]   r_len,        w_len_nxt;
  logic [ADDR_WIDTH:0]   r_word_cnt,   w_word_cnt_nxt;
  logic [1:0]            r_byte_cnt,   w_byte_cnt_nxt;
  logic [31:0]           r_word,       w_word_nxt;
  logic                  r_mem_we,     w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [31:0]           r_mem_wdata,  w_mem_wdata_nxt;
  logic                  r_busy,       w_busy_nxt;
  logic                  r_done,       w_done_nxt;
  logic                  r_stall,      w_stall_nxt;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]           r_sum,        w_sum_nxt;
  logic                  r_error,      w_error_nxt;
`endif

  logic                  w_in_ready;
  logic                  w_accept;
  logic [31:0]           w_asm_word;
  logic [ADDR_WIDTH:0]   w_start_len;
  logic [ADDR_WIDTH:0]   w_cnt_inc;

  assign w_in_ready  = (r_state == S_RECV) || (r_state == S_CHK);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_start_len = (bus.load_len > c_DEPTH_LEN) ? c_DEPTH_LEN : bus.load_len;
  assign w_cnt_inc   = r_word_cnt + c_ONE;

  always_comb begin
    w_asm_word = r_word;
    w_asm_word[{r_byte_cnt, 3'b000} +: 8] = bus.in_data;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_word_cnt_nxt  = r_word_cnt;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_word_nxt      = r_word;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;
    w_stall_nxt     = r_stall;
`ifdef LOADER_CHECKSUM_EN
    w_sum_nxt       = r_sum;
    w_error_nxt     = r_error;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_len_nxt      = w_start_len;
          w_word_cnt_nxt = '0;
          w_byte_cnt_nxt = '0;
          w_done_nxt     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          w_sum_nxt      = '0;
          w_error_nxt    = 1'b0;
`endif
          if (w_start_len == '0) begin
`ifdef LOADER_CHECKSUM_EN
            w_state_nxt = S_CHK;
            w_busy_nxt  = 1'b1;
            w_stall_nxt = 1'b1;
`else
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
`endif
          end else begin
            w_state_nxt = S_RECV;
            w_busy_nxt  = 1'b1;
            w_stall_nxt = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (w_accept) begin
          w_word_nxt     = w_asm_word;
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          // Register the write one cycle early so it is presented during WRITE.
          if (r_byte_cnt == 2'd3) begin
            w_state_nxt     = S_WRITE;
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = r_word_cnt[ADDR_WIDTH-1:0];
            w_mem_wdata_nxt = w_asm_word;
          end
        end
      end
      S_WRITE: begin
        w_word_cnt_nxt = w_cnt_inc;
        w_byte_cnt_nxt = '0;
`ifdef LOADER_CHECKSUM_EN
        w_sum_nxt      = r_sum + r_mem_wdata;
`endif
        if (w_cnt_inc == r_len) begin
`ifdef LOADER_CHECKSUM_EN
          w_state_nxt = S_CHK;
`else
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_stall_nxt = 1'b0;
          w_done_nxt  = 1'b1;
`endif
        end else begin
          w_state_nxt = S_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) begin
          w_word_nxt     = w_asm_word;
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_stall_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_error_nxt = (w_asm_word != r_sum);
          end
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_byte_cnt  <= '0;
      r_word      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_stall     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum       <= '0;
      r_error     <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_word      <= w_word_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_stall     <= w_stall_nxt;
`ifdef LOADER_CHECKSUM_EN
      r_sum       <= w_sum_nxt;
      r_error     <= w_error_nxt;
`endif
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.cpu_stall = r_stall;
`ifdef LOADER_CHECKSUM_EN
  assign bus.error     = r_error;
`endif
endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for instruction_loader: directed loads with random payloads, checked
// against a byte-list model of the expected memory image and timing.
module tb_instruction_loader;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
`ifdef LOADER_CHECKSUM_EN
  localparam int CHK_EXTRA = 4;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned t0;
  int unsigned last_we_cyc = 0;
  int          wbase;
  int unsigned lat;
  logic [7:0]  stim[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
`ifdef LOADER_CHECKSUM_EN
  logic        exp_err;
`endif

  instruction_loader_if #(.ADDR_WIDTH(AW)) itf ();
  instruction_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (itf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (itf.mem_we === 1'b1) begin
      wr_addr_q.push_back(itf.mem_addr);
      wr_data_q.push_back(itf.mem_wdata);
      last_we_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stim.push_back(w[8*b +: 8]);
  endtask

  function automatic logic [31:0] model_word(input int i);
    return {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
  endfunction

`ifdef LOADER_CHECKSUM_EN
  // Appends the checksum word (sum of data words plus delta) and sets the expected flag.
  task automatic add_chk(input int n, input logic [31:0] delta);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < n; i++) s = s + model_word(i);
    push_word(s + delta);
    exp_err = (delta != 32'd0);
  endtask
`endif

  // mode 0: in_valid held high, 1: toggling, 2: random
  task automatic run_load(input logic [AW:0] len, input int mode, input int budget);
    int   idx;
    int   k;
    int   n;
    logic v;
    wbase = wr_addr_q.size();
    @(negedge clk);
    itf.start    = 1'b1;
    itf.load_len = len;
    @(negedge clk);
    itf.start = 1'b0;
    t0  = cyc;
    idx = 0;
    k   = 0;
    while (itf.done !== 1'b1 && k < budget) begin
      if (idx < stim.size()) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = (k % 2 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        itf.in_valid = v;
        itf.in_data  = stim[idx];
        if (v && itf.in_ready === 1'b1) idx++;
      end else begin
        itf.in_valid = 1'b0;
        itf.in_data  = 8'($urandom);
      end
      @(negedge clk);
      k++;
    end
    itf.in_valid = 1'b0;
    lat = cyc - t0;
    n = (int'(len) > DEPTH) ? DEPTH : int'(len);
    check("done_reached", itf.done, 1'b1);
    check("stall_after_done", itf.cpu_stall, 1'b0);
    check("busy_after_done", itf.busy, 1'b0);
    check("ready_after_done", itf.in_ready, 1'b0);
    check("write_count", 64'(wr_addr_q.size() - wbase), 64'(n));
    for (int i = 0; i < n && (wbase + i) < wr_addr_q.size(); i++) begin
      check("write_addr", 64'(wr_addr_q[wbase+i]), 64'(i));
      check("write_data", 64'(wr_data_q[wbase+i]), 64'(model_word(i)));
    end
    if (n > 0 && CHK_EXTRA == 0) check("done_after_last_we", 64'(cyc - last_we_cyc), 64'd1);
`ifdef LOADER_CHECKSUM_EN
    check("error_flag", itf.error, exp_err);
`endif
  endtask

  initial begin
    int idx;
    itf.start    = 1'b0;
    itf.load_len = '0;
    itf.in_data  = '0;
    itf.in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", itf.in_ready, 1'b0);
    check("rst_mem_we", itf.mem_we, 1'b0);
    check("rst_mem_addr", 64'(itf.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(itf.mem_wdata), 64'd0);
    check("rst_busy", itf.busy, 1'b0);
    check("rst_done", itf.done, 1'b0);
    check("rst_stall", itf.cpu_stall, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    check("rst_error", itf.error, 1'b0);
`endif
    rst = 1'b0;
    itf.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_in_ready", itf.in_ready, 1'b0);
    check("idle_busy", itf.busy, 1'b0);
    itf.in_valid = 1'b0;

    // Two fixed words, valid held high.
    stim.delete();
    push_word(32'h12345678);
    push_word(32'hDEADBEEF);
`ifdef LOADER_CHECKSUM_EN
    add_chk(2, 32'd0);
`endif
    run_load(11'd2, 0, 100);
    check("latency_2words", 64'(lat), 64'(10 + CHK_EXTRA));

    // Same load with in_valid toggling.
    run_load(11'd2, 1, 200);

    // Random payload with random valid gaps.
    stim.delete();
    for (int i = 0; i < 5; i++) push_word($urandom);
`ifdef LOADER_CHECKSUM_EN
    add_chk(5, 32'd0);
`endif
    run_load(11'd5, 2, 400);

    // Zero-length load.
    stim.delete();
`ifdef LOADER_CHECKSUM_EN
    add_chk(0, 32'd0);
`endif
    run_load(11'd0, 0, 50);
    check("latency_len0", 64'(lat), 64'(CHK_EXTRA));

    // Oversized request clamps to DEPTH words.
    stim.delete();
    for (int i = 0; i < DEPTH; i++) push_word($urandom);
`ifdef LOADER_CHECKSUM_EN
    add_chk(DEPTH, 32'd0);
`endif
    run_load(11'd2000, 0, 6000);
    check("last_addr_clamped", 64'(wr_addr_q[wr_addr_q.size()-1]), 64'(DEPTH-1));

    // Reset after 6 bytes of a 3-word load; a stray start in RECV is ignored.
    stim.delete();
    for (int i = 0; i < 3; i++) push_word($urandom);
    wbase = wr_addr_q.size();
    @(negedge clk);
    itf.start    = 1'b1;
    itf.load_len = 11'd3;
    @(negedge clk);
    itf.start = 1'b0;
    idx = 0;
    for (int k = 0; k < 40 && idx < 6; k++) begin
      itf.start    = (k == 2);
      itf.load_len = '0;
      itf.in_valid = 1'b1;
      itf.in_data  = stim[idx];
      if (itf.in_ready === 1'b1) idx++;
      @(negedge clk);
    end
    itf.start    = 1'b0;
    itf.in_valid = 1'b0;
    check("bytes_before_rst", 64'(idx), 64'd6);
    check("start_ignored_busy", itf.busy, 1'b1);
    check("start_ignored_done", itf.done, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    itf.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    itf.in_valid = 1'b0;
    check("abort_write_count", 64'(wr_addr_q.size() - wbase), 64'd1);
    if (wr_addr_q.size() > wbase) begin
      check("abort_addr", 64'(wr_addr_q[wbase]), 64'd0);
      check("abort_data", 64'(wr_data_q[wbase]), 64'(model_word(0)));
    end
    check("abort_busy", itf.busy, 1'b0);
    check("abort_done", itf.done, 1'b0);
    check("abort_stall", itf.cpu_stall, 1'b0);
    check("abort_in_ready", itf.in_ready, 1'b0);

    // Fresh load from IDLE after the abort.
    stim.delete();
    for (int i = 0; i < 3; i++) push_word($urandom);
`ifdef LOADER_CHECKSUM_EN
    add_chk(3, 32'd0);
`endif
    run_load(11'd3, 2, 300);

`ifdef LOADER_CHECKSUM_EN
    stim.delete();
    push_word(32'h00000001);
    push_word(32'hFFFFFFFF);
    push_word(32'h00000000);
    exp_err = 1'b0;
    run_load(11'd2, 0, 100);
    stim.delete();
    push_word(32'h00000001);
    push_word(32'hFFFFFFFF);
    push_word(32'h00000001);
    exp_err = 1'b1;
    run_load(11'd2, 1, 200);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
